// File: rtl/knns_seq_td_pkg.sv
// Shared types and helpers for the sequential k-NN selector (knns_seq_td).
// Optional macro: KNNS_SQ_EUCLID_EN selects squared-Euclidean distance
// instead of taxicab, widening the distance field to keep the sentinel
// unreachable.
package knns_pkg;

    // Distance width for a given coordinate width, with the metric applied.
    function automatic int unsigned knns_dw(input int unsigned w);
`ifdef KNNS_SQ_EUCLID_EN
        return 2 * w + 2;
`else
        return w + 2;
`endif
    endfunction

    // Ceiling log2, used to size the fill counter (0..K needs clog2(K+1)).
    function automatic int unsigned knns_clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(v)) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    localparam int unsigned KNNS_W_DEF  = 15;
    localparam int unsigned KNNS_DW_DEF = knns_dw(KNNS_W_DEF);
    // Empty-slot distance marker at the default width; always above any reachable d.
    localparam logic [KNNS_DW_DEF-1:0] KNNS_SENTINEL = '1;

endpackage

// File: rtl/knns_seq_td_if.sv
// Bus bundle for knns_seq_td: query/candidate stream in, sorted list out.
// Widths follow KNNS_SQ_EUCLID_EN through knns_dw().
interface knns_seq_td_if
    import knns_pkg::*;
#(
    parameter int unsigned W = 15,
    parameter int unsigned K = 4
);
    localparam int unsigned DW = knns_dw(W);
    localparam int unsigned FW = knns_clog2(K + 1);

    logic                clr;
    logic [2*W-1:0]      g_input;
    logic [2*W-1:0]      e_input;
    logic                e_valid;
    logic [K*2*W-1:0]    o;
    logic [K*DW-1:0]     o_dist;
    logic [FW-1:0]       o_fill;

    modport master (
        output clr, g_input, e_input, e_valid,
        input  o, o_dist, o_fill
    );

    modport slave (
        input  clr, g_input, e_input, e_valid,
        output o, o_dist, o_fill
    );

endinterface

// File: rtl/knns_dist.sv
// Combinational distance unit between a candidate and the query point.
// KNNS_SQ_EUCLID_EN selects squared Euclidean; default is taxicab.
module knns_dist
    import knns_pkg::*;
#(
    parameter  int unsigned W  = 15,
    localparam int unsigned DW = knns_dw(W)
) (
    input  logic [2*W-1:0] i_e,
    input  logic [2*W-1:0] i_g,
    output logic [DW-1:0]  o_d
);
    logic [W-1:0] w_dx;
    logic [W-1:0] w_dy;

    // Per-axis absolute differences, computed in unsigned arithmetic.
    always_comb begin
        w_dx = (i_e[2*W-1:W] >= i_g[2*W-1:W]) ? (i_e[2*W-1:W] - i_g[2*W-1:W])
                                              : (i_g[2*W-1:W] - i_e[2*W-1:W]);
        w_dy = (i_e[W-1:0] >= i_g[W-1:0]) ? (i_e[W-1:0] - i_g[W-1:0])
                                          : (i_g[W-1:0] - i_e[W-1:0]);
    end

`ifdef KNNS_SQ_EUCLID_EN
    logic [2*W-1:0] w_sqx;
    logic [2*W-1:0] w_sqy;

    // Squared Euclidean metric; the sum fits in 2W+1 bits.
    always_comb begin
        w_sqx = (2*W)'(w_dx) * (2*W)'(w_dx);
        w_sqy = (2*W)'(w_dy) * (2*W)'(w_dy);
        o_d   = DW'(w_sqx) + DW'(w_sqy);
    end
`else
    // Taxicab metric; the sum fits in W+1 bits.
    always_comb begin
        o_d = DW'(w_dx) + DW'(w_dy);
    end
`endif

endmodule

// File: rtl/knns_seq_td.sv
// Sequential K-nearest-neighbour selector: keeps a sorted register list of
// the K closest candidates since the last clear. Metric set by the
// KNNS_SQ_EUCLID_EN macro (see knns_dist).
module knns_seq_td
    import knns_pkg::*;
#(
    parameter int unsigned W = 15,
    parameter int unsigned K = 4
) (
    input logic          clk,
    input logic          rst,
    knns_seq_td_if.slave bus
);
    localparam int unsigned DW = knns_dw(W);
    localparam int unsigned FW = knns_clog2(K + 1);
    localparam int unsigned PW = 2 * W;

    logic [K-1:0][PW-1:0] r_val;
    logic [K-1:0][DW-1:0] r_dist;
    logic [FW-1:0]        r_fill;
    logic [K-1:0][PW-1:0] w_val_nxt;
    logic [K-1:0][DW-1:0] w_dist_nxt;
    logic [DW-1:0]        w_d;
    logic [K-1:0]         w_lt;

    knns_dist #(.W(W)) u_dist (
        .i_e (bus.e_input),
        .i_g (bus.g_input),
        .o_d (w_d)
    );

    // Parallel strict less-than against every slot; ties keep earlier arrivals first.
    always_comb begin
        for (int unsigned i = 0; i < K; i++) begin
            w_lt[i] = w_d < r_dist[i];
        end
    end

    // Insert/shift network. Because the list is sorted, w_lt is set for every
    // slot at or after the insertion point, so the first set bit takes the new
    // entry and each later set bit takes its upper neighbour.
    always_comb begin
        w_val_nxt  = r_val;
        w_dist_nxt = r_dist;
        if (w_lt[0]) begin
            w_val_nxt[0]  = bus.e_input;
            w_dist_nxt[0] = w_d;
        end
        for (int unsigned i = 1; i < K; i++) begin
            if (w_lt[i]) begin
                if (w_lt[i-1]) begin
                    w_val_nxt[i]  = r_val[i-1];
                    w_dist_nxt[i] = r_dist[i-1];
                end else begin
                    w_val_nxt[i]  = bus.e_input;
                    w_dist_nxt[i] = w_d;
                end
            end
        end
    end

    // List and fill registers: reset/clear empty the list, accepts insert when closer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_val  <= '0;
            r_dist <= '1;
            r_fill <= '0;
        end else if (bus.clr) begin
            r_val  <= '0;
            r_dist <= '1;
            r_fill <= '0;
        end else if (bus.e_valid && (|w_lt)) begin
            r_val  <= w_val_nxt;
            r_dist <= w_dist_nxt;
            if (r_fill != FW'(K)) begin
                r_fill <= r_fill + 1'b1;
            end
        end
    end

    assign bus.o      = r_val;
    assign bus.o_dist = r_dist;
    assign bus.o_fill = r_fill;

endmodule

// File: doc/knns_seq_td.md
# knns_seq_td

Sequential K-nearest-neighbour selector for the garbled-circuit k-NN flow. It takes one query point and a stream of candidate points, one candidate per accepted cycle. It keeps a sorted, registered list of the K closest candidates seen since the last clear, and exposes that list as its outputs. It generalises the single-minimum selector in the same k-NN block family to K results, registered outputs, a valid qualifier, an explicit clear and a fill count.

## Interface
- W, default 15: coordinate width. A point is {x, y}, 2W bits, with x in the upper W bits.
- K, default 4: number of neighbours kept, K ≥ 1.
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- clr  in  1  synchronous clear of the list, active-high.
- g_input  in  2W  query point {x2, y2}. Held stable for the whole stream.
- e_input  in  2W  candidate point {x1, y1}.
- e_valid  in  1  candidate qualifier. Each cycle with e_valid high accepts one candidate.
- o  out  K·2W  sorted neighbour values. Slot i is o[(i+1)·2W-1 : i·2W]; slot 0 is the nearest.
- o_dist  out  K·DW  distance of each slot, same packing with width DW.
- o_fill  out  clog2(K+1)  number of occupied slots, saturating at K.

## Operation
- Distance: d = |x1−x2| + |y1−y2|, DW = W+2 bits, unsigned, no overflow. The maximum value is 2(2^W−1).
- Empty slot: value 0, distance all-ones. This sentinel is strictly greater than any reachable d.
- Accept cycle (e_valid=1, clr=0):
  - Compare d in parallel against every slot using strict less-than: lt[i] = d < dist[i].
  - Insertion point p = lowest i with lt[i]=1.
  - Slots below p are unchanged. Slot p receives {e_input, d}. Slots p..K−2 shift down by one. Slot K−1's old entry is discarded.
  - If no lt[i] is set, the list is unchanged.
- Ties: a new candidate equal in distance to an existing entry goes after it, so earlier arrivals win.
- o_fill increments on every insertion while below K, and saturates at K.
- The list stays monotonically non-decreasing in distance from slot 0 to slot K−1. Verification checks this as an invariant.
- clr=1: all slots become empty and o_fill becomes 0. clr takes priority; a simultaneous e_valid candidate is dropped.
- No state machine. The state is the K-slot register file plus o_fill.

## Timing
- Reset values: every o slot 0, every o_dist slot all-ones, o_fill 0. rst takes effect immediately, including mid-stream, and the stream is abandoned.
- Latency 1 cycle: a candidate accepted at edge t is visible on o, o_dist and o_fill after edge t.
- Throughput: one candidate per cycle, with no back-pressure.
- Changing g_input mid-stream is legal but mixes metrics. Without clr, the result for that stream is undefined.
- All outputs come straight from registers, with no combinational path from the inputs.

## Configuration
- KNNS_SQ_EUCLID_EN defined:
  - d = (x1−x2)² + (y1−y2)².
  - DW = 2W+2, which keeps the all-ones sentinel unreachable.
  - Ordering, tie and clear rules are unchanged.
- KNNS_SQ_EUCLID_EN undefined: taxicab distance as above, DW = W+2.

## Structure
- Package knns_pkg:
  - Function knns_dw(W), which returns DW with the macro applied.
  - Localparam for the sentinel (all-ones of DW).
  - Fill-width helper clog2.
- Sub-module knns_dist: a combinational distance unit with parameter W. It holds the macro-selected metric and drives a DW-bit d.
- Top level: K comparators, the insertion-point priority logic, the shift/insert register file and the fill counter.

## Test plan
All scenarios use W=4, K=3 and taxicab distance (DW=6) unless stated otherwise.
- Reset: assert rst → o=0, each o_dist slot 6'h3F, o_fill=0, all immediately and without a clock edge.
- Fill and tie: query (0,0); candidates (3,3), (1,0), (2,2), (0,1) on consecutive cycles → distances 6, 1, 4, 1. Final list: slot0 (1,0)/1, slot1 (0,1)/1, slot2 (2,2)/4; o_fill=3.
- Reject and front insert, continuing from the previous scenario:
  - Candidate (5,5) with d=10 → list unchanged.
  - Then (0,0) with d=0 → list becomes (0,0)/0, (1,0)/1, (0,1)/1.
- Extreme and gaps: empty list, query (0,0). Apply candidate (15,15) with e_valid=0 → ignored. Apply it with e_valid=1 → slot0 (15,15)/6'h1E, o_fill=1.
- Clear and reset collision:
  - Full list, clr=1 with e_valid=1 → list empty, o_fill=0, candidate dropped.
  - Separately, rst pulsed between edges mid-stream → reset values appear immediately.
- KNNS_SQ_EUCLID_EN defined: query (0,0), candidate (15,15) → d=450, with DW=10 and sentinel 10'h3FF.
